// File: rtl/decoder_onehot_scan.sv
// Registered binary-to-one-hot decoder with a scan engine that walks a bounded
// address range up or down with a programmable dwell per line, or freezes in hold.
module decoder_onehot_scan #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned DWELL_W = 8,
  localparam int unsigned OUT_W  = 2 ** ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic               in_valid,
  input  logic [ADDR_W-1:0]  in_addr,
  input  logic [ADDR_W-1:0]  lo_addr,
  input  logic [ADDR_W-1:0]  hi_addr,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   y,
  output logic [ADDR_W-1:0]  cur_addr,
  output logic               out_valid,
  output logic               wrap,
  output logic               range_err
);

  typedef enum logic [1:0] {
    ModeDirect = 2'b00,
    ModeUp     = 2'b01,
    ModeDown   = 2'b10,
    ModeHold   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {StIdle, StDirect, StScan, StHold} state_e;

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   y_q, y_d;
  logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
  logic               out_valid_q, out_valid_d;
  logic               wrap_q, wrap_d;
  logic               range_err_q, range_err_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  // A valid scan exists (running or frozen in hold) in direction scan_down_q.
  logic               scan_live_q, scan_live_d;
  logic               scan_down_q, scan_down_d;

  mode_e             mode_sel;
  logic              want_down;
  logic              resume;
  logic              load;
  logic [ADDR_W-1:0] load_addr;

  assign mode_sel  = mode_e'(mode);
  assign want_down = (mode_sel == ModeDown);
  assign resume    = scan_live_q && (scan_down_q == want_down) &&
                     ((state_q == StScan) || (state_q == StHold));

  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    cur_addr_d  = cur_addr_q;
    out_valid_d = out_valid_q;
    wrap_d      = 1'b0;
    range_err_d = 1'b0;
    cnt_d       = cnt_q;
    scan_live_d = scan_live_q;
    scan_down_d = scan_down_q;
    load        = 1'b0;
    load_addr   = cur_addr_q;

    if (!en) begin
      state_d     = StIdle;
      y_d         = '0;
      out_valid_d = 1'b0;
      cnt_d       = '0;
      scan_live_d = 1'b0;
    end else begin
      unique case (mode_sel)
        ModeDirect: begin
          state_d     = StDirect;
          cnt_d       = '0;
          scan_live_d = 1'b0;
          if (in_valid) begin
            load      = 1'b1;
            load_addr = in_addr;
          end
        end
        ModeHold: begin
          state_d = StHold;
        end
        ModeUp, ModeDown: begin
          state_d     = StScan;
          scan_down_d = want_down;
          if (lo_addr > hi_addr) begin
            range_err_d = 1'b1;
            y_d         = '0;
            out_valid_d = 1'b0;
            cnt_d       = '0;
            scan_live_d = 1'b0;
          end else if (!resume) begin
            load        = 1'b1;
            load_addr   = want_down ? hi_addr : lo_addr;
            cnt_d       = '0;
            scan_live_d = 1'b1;
          end else if (cnt_q < dwell) begin
            cnt_d = cnt_q + DWELL_W'(1);
          end else begin
            // Also catches a dwell shortened below the running count.
            cnt_d = '0;
            load  = 1'b1;
            if (!want_down) begin
              if ((cur_addr_q >= hi_addr) || (cur_addr_q < lo_addr)) begin
                load_addr = lo_addr;
                wrap_d    = 1'b1;
              end else begin
                load_addr = cur_addr_q + ADDR_W'(1);
              end
            end else begin
              if ((cur_addr_q <= lo_addr) || (cur_addr_q > hi_addr)) begin
                load_addr = hi_addr;
                wrap_d    = 1'b1;
              end else begin
                load_addr = cur_addr_q - ADDR_W'(1);
              end
            end
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    if (load) begin
      cur_addr_d  = load_addr;
      y_d         = OUT_W'(1) << load_addr;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      y_q         <= '0;
      cur_addr_q  <= '0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
      range_err_q <= 1'b0;
      cnt_q       <= '0;
      scan_live_q <= 1'b0;
      scan_down_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      cur_addr_q  <= cur_addr_d;
      out_valid_q <= out_valid_d;
      wrap_q      <= wrap_d;
      range_err_q <= range_err_d;
      cnt_q       <= cnt_d;
      scan_live_q <= scan_live_d;
      scan_down_q <= scan_down_d;
    end
  end

  assign y         = y_q;
  assign cur_addr  = cur_addr_q;
  assign out_valid = out_valid_q;
  assign wrap      = wrap_q;
  assign range_err = range_err_q;

endmodule

// File: tb/tb_decoder_onehot_scan.sv
// Self-checking bench for decoder_onehot_scan: directed scenarios plus a random
// run compared against a behavioural model of the decode and scan rules.
module tb_decoder_onehot_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        in_valid = 1'b0;
  logic [5:0]  in_addr = '0;
  logic [5:0]  lo_addr = '0;
  logic [5:0]  hi_addr = '0;
  logic [7:0]  dwell = '0;
  logic [63:0] y;
  logic [5:0]  cur_addr;
  logic        out_valid;
  logic        wrap;
  logic        range_err;
  logic [72:0] got;

  int checks = 0;
  int failures = 0;

  // Model: address shown, valid, wrap, error, cycles spent on current line,
  // and which scan (0 none, 1 up, 2 down) is live or frozen.
  logic [5:0] m_cur;
  bit         m_ov, m_wrap, m_err;
  int         m_cnt;
  int         m_scan;

  always #5 clk = ~clk;

  decoder_onehot_scan #(.ADDR_W(6), .DWELL_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .in_valid (in_valid),
    .in_addr  (in_addr),
    .lo_addr  (lo_addr),
    .hi_addr  (hi_addr),
    .dwell    (dwell),
    .y        (y),
    .cur_addr (cur_addr),
    .out_valid(out_valid),
    .wrap     (wrap),
    .range_err(range_err)
  );

  assign got = {y, cur_addr, out_valid, wrap, range_err};

  task automatic model_reset();
    m_cur = '0; m_ov = 0; m_wrap = 0; m_err = 0; m_cnt = 0; m_scan = 0;
  endtask

  task automatic model_edge();
    int kind;
    m_wrap = 0;
    if (!en) begin
      m_ov = 0; m_err = 0; m_cnt = 0; m_scan = 0;
    end else if (mode == 2'b00) begin
      m_err = 0; m_scan = 0; m_cnt = 0;
      if (in_valid) begin
        m_cur = in_addr;
        m_ov  = 1;
      end
    end else if (mode == 2'b11) begin
      m_err = 0;
    end else begin
      kind = (mode == 2'b01) ? 1 : 2;
      if (lo_addr > hi_addr) begin
        m_err = 1; m_ov = 0; m_cnt = 0; m_scan = 0;
      end else begin
        m_err = 0;
        if (m_scan != kind) begin
          m_cur = (kind == 1) ? lo_addr : hi_addr;
          m_ov = 1; m_cnt = 0; m_scan = kind;
        end else if (m_cnt < int'(dwell)) begin
          m_cnt++;
        end else begin
          m_cnt = 0;
          if (kind == 1) begin
            if (m_cur >= lo_addr && m_cur < hi_addr) m_cur = m_cur + 6'd1;
            else begin m_cur = lo_addr; m_wrap = 1; end
          end else begin
            if (m_cur > lo_addr && m_cur <= hi_addr) m_cur = m_cur - 6'd1;
            else begin m_cur = hi_addr; m_wrap = 1; end
          end
        end
      end
    end
  endtask

  function automatic logic [72:0] exp_vec();
    logic [63:0] ey;
    ey = m_ov ? (64'd1 << m_cur) : 64'd0;
    return {ey, m_cur, m_ov, m_wrap, m_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    en = 0; mode = 2'b00; in_valid = 0;
    #1 rst_n = 0;
    #2;
    checks++;
    if (got !== 73'd0) begin
      failures++;
      $display("FAIL reset_async: got %h want 0", got);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (got !== 73'd0) begin
      failures++;
      $display("FAIL reset_held: got %h want 0", got);
    end
    model_reset();
    #2 rst_n = 1;
  endtask

  task automatic test_direct();
    logic [5:0] addrs [3];
    addrs = '{6'd0, 6'd5, 6'd63};
    en = 1; mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_addr = addrs[i];
      tick();
      checks++;
      if (y !== (64'd1 << addrs[i]) || out_valid !== 1'b1 || cur_addr !== addrs[i]) begin
        failures++;
        $display("FAIL direct_%0d: got y=%h cur=%0d ov=%b want y=%h cur=%0d ov=1",
                 i, y, cur_addr, out_valid, 64'd1 << addrs[i], addrs[i]);
      end
      checks++;
      if (got !== exp_vec()) begin
        failures++;
        $display("FAIL direct_model_%0d: got %h want %h", i, got, exp_vec());
      end
    end
    in_valid = 0; in_addr = 6'd9;
    tick();
    checks++;
    if (y !== 64'h8000_0000_0000_0000 || cur_addr !== 6'd63 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL direct_hold: got y=%h cur=%0d ov=%b want y=8000000000000000 cur=63 ov=1",
               y, cur_addr, out_valid);
    end
  endtask

  task automatic test_scan_up();
    int exp_cur [9];
    bit exp_wr [9];
    exp_cur = '{3, 3, 4, 4, 5, 5, 3, 3, 4};
    exp_wr  = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    mode = 2'b01; lo_addr = 6'd3; hi_addr = 6'd5; dwell = 8'd1;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (cur_addr !== 6'(exp_cur[i]) || wrap !== exp_wr[i] ||
          y !== (64'd1 << exp_cur[i]) || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL scan_up_%0d: got cur=%0d wrap=%b y=%h want cur=%0d wrap=%b",
                 i, cur_addr, wrap, y, exp_cur[i], exp_wr[i]);
      end
      checks++;
      if (got !== exp_vec()) begin
        failures++;
        $display("FAIL scan_up_model_%0d: got %h want %h", i, got, exp_vec());
      end
    end
  endtask

  task automatic test_scan_down();
    int exp_cur [7];
    bit exp_wr [7];
    exp_cur = '{2, 1, 0, 2, 1, 0, 2};
    exp_wr  = '{0, 0, 0, 1, 0, 0, 1};
    mode = 2'b10; lo_addr = 6'd0; hi_addr = 6'd2; dwell = 8'd0;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (cur_addr !== 6'(exp_cur[i]) || wrap !== exp_wr[i] ||
          y !== (64'd1 << exp_cur[i]) || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL scan_down_%0d: got cur=%0d wrap=%b y=%h want cur=%0d wrap=%b",
                 i, cur_addr, wrap, y, exp_cur[i], exp_wr[i]);
      end
    end
  endtask

  task automatic test_range_err();
    mode = 2'b01; lo_addr = 6'd7; hi_addr = 6'd4; dwell = 8'd0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (range_err !== 1'b1 || y !== 64'd0 || out_valid !== 1'b0 || wrap !== 1'b0) begin
        failures++;
        $display("FAIL range_err_%0d: got err=%b y=%h ov=%b wrap=%b want err=1 y=0 ov=0 wrap=0",
                 i, range_err, y, out_valid, wrap);
      end
    end
    hi_addr = 6'd9;
    tick();
    checks++;
    if (range_err !== 1'b0 || cur_addr !== 6'd7 || y !== 64'h80 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL range_recover: got err=%b cur=%0d y=%h ov=%b want err=0 cur=7 y=80 ov=1",
               range_err, cur_addr, y, out_valid);
    end
    checks++;
    if (got !== exp_vec()) begin
      failures++;
      $display("FAIL range_model: got %h want %h", got, exp_vec());
    end
  endtask

  task automatic test_hold();
    mode = 2'b00; in_valid = 0;
    tick();
    mode = 2'b01; lo_addr = 6'd2; hi_addr = 6'd10; dwell = 8'd2;
    repeat (8) tick();
    checks++;
    if (cur_addr !== 6'd4) begin
      failures++;
      $display("FAIL hold_setup: got cur=%0d want 4", cur_addr);
    end
    mode = 2'b11;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (cur_addr !== 6'd4 || y !== 64'h10 || out_valid !== 1'b1 || wrap !== 1'b0) begin
        failures++;
        $display("FAIL hold_frozen_%0d: got cur=%0d y=%h ov=%b wrap=%b want cur=4 y=10 ov=1",
                 i, cur_addr, y, out_valid, wrap);
      end
    end
    mode = 2'b01;
    tick();
    checks++;
    if (cur_addr !== 6'd4) begin
      failures++;
      $display("FAIL hold_resume0: got cur=%0d want 4", cur_addr);
    end
    tick();
    checks++;
    if (cur_addr !== 6'd5 || y !== 64'h20) begin
      failures++;
      $display("FAIL hold_resume1: got cur=%0d y=%h want cur=5 y=20", cur_addr, y);
    end
    checks++;
    if (got !== exp_vec()) begin
      failures++;
      $display("FAIL hold_model: got %h want %h", got, exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    repeat (2) tick();
    #2 rst_n = 0;
    #1;
    checks++;
    if (got !== 73'd0) begin
      failures++;
      $display("FAIL reset_mid: got %h want 0", got);
    end
    model_reset();
    #2 rst_n = 1;
    en = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (y !== 64'd0 || out_valid !== 1'b0 || got !== exp_vec()) begin
        failures++;
        $display("FAIL reset_release_%0d: got %h want %h", i, got, exp_vec());
      end
    end
    en = 1;
    tick();
    checks++;
    if (cur_addr !== 6'd2 || out_valid !== 1'b1 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset_reenter: got cur=%0d ov=%b wrap=%b want cur=2 ov=1 wrap=0",
               cur_addr, out_valid, wrap);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      in_valid = 1'($urandom_range(0, 1));
      in_addr  = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) begin
        lo_addr = 6'($urandom_range(0, 12));
        hi_addr = 6'($urandom_range(0, 12));
      end
      if ($urandom_range(0, 15) == 0) dwell = 8'($urandom_range(0, 3));
      tick();
      checks++;
      if (got !== exp_vec()) begin
        failures++;
        $display("FAIL random_%0d: got %h want %h", i, got, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_direct();
    test_scan_up();
    test_scan_down();
    test_range_err();
    test_hold();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decoder_onehot_scan.md
Name: decoder_onehot_scan

Overview:
- Parametrised registered binary-to-one-hot decoder: ADDR_W-bit address in, 2**ADDR_W one-hot lines out.
- Adds a sequential scan engine. The output can walk through an address range (up or down) with a programmable dwell per line, or freeze.
- Drives row/bank select and strobe sequencing in the datapath; supersedes the fixed-width combinational decoder tree.

Parameters:
- ADDR_W, 6, address width; output width OUT_W = 2**ADDR_W (legal 1..8).
- DWELL_W, 8, width of the dwell counter (cycles held per scanned line).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- en  input  1  global enable; low forces the output lines to zero.
- mode  input  2  00 direct, 01 scan-up, 10 scan-down, 11 hold.
- in_valid  input  1  direct-mode address strobe.
- in_addr  input  ADDR_W  direct-mode address.
- lo_addr  input  ADDR_W  scan range low bound (inclusive).
- hi_addr  input  ADDR_W  scan range high bound (inclusive).
- dwell  input  DWELL_W  extra cycles per scanned line; each line is held dwell+1 cycles.
- y  output  OUT_W  registered one-hot (or all-zero) select.
- cur_addr  output  ADDR_W  registered binary index of the asserted bit.
- out_valid  output  1  high when y holds exactly one asserted bit.
- wrap  output  1  one-cycle pulse on scan wrap-around.
- range_err  output  1  registered flag: scan mode is active with lo_addr > hi_addr.

Behaviour:
- Reset (rst_n low, asynchronous): y=0, cur_addr=0, out_valid=0, wrap=0, range_err=0, dwell counter=0, state IDLE.
- All outputs are registered. Invariant: out_valid=1 implies y == 1<<cur_addr.
- States: IDLE, DIRECT, SCAN, HOLD. The next state is taken from mode each cycle while en=1. en=0 -> IDLE next cycle.
- IDLE:
  - y=0, out_valid=0, wrap=0, dwell counter cleared.
  - cur_addr keeps its last value.
- DIRECT (mode 00):
  - in_valid=1 -> next cycle y=1<<in_addr, cur_addr=in_addr, out_valid=1 (latency 1).
  - in_valid=0 -> y and cur_addr hold their previous value; out_valid is unchanged.
  - Back-to-back strobes update every cycle.
- SCAN entry (mode 01 or 10, first cycle after a change from any other mode or from IDLE):
  - Load cur_addr with lo_addr (up) or hi_addr (down).
  - Drive y to match, out_valid=1, dwell counter=0.
- SCAN running:
  - Dwell counter increments each cycle. When it equals dwell, the counter clears and the address steps by ±1 on the next edge.
  - Up: stepping past hi_addr reloads lo_addr and pulses wrap for exactly the cycle in which the reloaded address first appears on y.
  - Down: stepping past lo_addr reloads hi_addr, with the same wrap timing.
  - lo_addr==hi_addr: the address stays constant and wrap pulses every dwell+1 cycles.
  - dwell=0: step every cycle.
- Switching directly between scan-up and scan-down is a mode change and re-enters SCAN, reloading the start bound.
- Bounds or dwell changed mid-scan:
  - Sampled every cycle and used from the next step decision.
  - If cur_addr lies outside the new range, the next step reloads the start bound with a wrap pulse.
- range_err:
  - In scan modes with lo_addr > hi_addr: range_err=1, y=0, out_valid=0, no wrap, dwell counter held at 0.
  - Clearing the condition re-enters SCAN as on a fresh entry.
  - range_err=0 in all non-scan states.
- HOLD (mode 11): y, cur_addr, out_valid and the dwell counter freeze. wrap=0.
- Leaving HOLD back to the same scan mode resumes from the frozen address and count, with no reload. Any other mode change reloads.
- Simultaneous events: en=0 has priority over mode; mode change has priority over the dwell step. A wrap coinciding with en falling is suppressed.
- Reset asserted mid-scan clears immediately. After release, state is IDLE until the first enabled cycle.

Test Plan:
- Reset, en=1, mode=00, in_valid pulses with in_addr=0,5,63 on consecutive cycles -> y=0x1, 0x20, 1<<63 each one cycle later; out_valid=1 from the first.
- mode=01, lo=3, hi=5, dwell=1 -> cur_addr 3,3,4,4,5,5,3,... ; wrap high on the first cycle of each returning 3.
- mode=10, lo=0, hi=2, dwell=0 -> cur_addr 2,1,0,2,...; wrap on each return to 2; y one-hot throughout.
- Scan with lo=7, hi=4 -> range_err=1, y=0, out_valid=0; set hi=9 -> the next cycle starts at 7, range_err=0.
- Mid-scan at cur_addr=4: mode=11 for 5 cycles (y frozen, no wrap), then mode=01 -> resumes at 4 with the preserved dwell count.
- Mid-scan rst_n low for a partial cycle -> outputs 0 immediately; after release, en=0 keeps y=0 and out_valid=0.
